prog_data_mem: RTL and testbench
================================

# prog_data_mem

Parametrised single-clock program/data memory for the tiny CPU. It replaces the fixed 32-byte program store / 128-byte data RAM pair and keeps the three-phase flow:
- **IN**: enter the program byte by byte from the switches and a push-button.
- **CHECK**: step through the stored program on the display.
- **RUN**: serve CPU reads and writes over the shared 8-bit data bus.

It sits between the address register / CPU datapath and the board I/O (switches, key, display driver).

## Interface
Parameters:
- DATA_W, 8, data/bus width
- ADDR_W, 16, CPU address width
- ROM_DEPTH, 32, program-store entries; power of two; ROM_AW = log2(ROM_DEPTH)
- RAM_DEPTH, 128, data-RAM entries

Ports:
- clk  in  1  system clock (divided board clock); all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cpustate  in  2  00 IDLE, 01 IN, 10 CHECK, 11 RUN
- key  in  1  push-button, active-low, asynchronous to clk
- sw  in  DATA_W  switch value stored on an IN press
- addr  in  ADDR_W  CPU address (RUN)
- data_in  in  DATA_W  CPU write data (RUN)
- read  in  1  read request, level, sampled each clk (RUN)
- write  in  1  write request, level, sampled each clk (RUN)
- data_out  out  DATA_W  read data; high-Z unless cpustate==11
- rd_valid  out  1  data_out holds the result of the read sampled on the previous edge
- check_out  out  DATA_W  rom[check_ptr]; high-Z unless cpustate==10
- load_ptr  out  ROM_AW  next program-store entry to be loaded
- rom_full  out  1  all ROM_DEPTH entries loaded
- err  out  1  sticky illegal-access flag (RUN)

## Operation
- **Key handling**
  - key passes through a 2-flop synchronizer (k1, k2), then a history flop kp.
  - A press is `k2==0 && kp==1`: one pulse per physical press.
  - k1, k2 and kp reset to 1.
- **IN**, on each press:
  - if !rom_full: rom[load_ptr] <= sw; load_ptr increments.
  - A write at load_ptr==ROM_DEPTH-1 sets rom_full; load_ptr then stays at ROM_DEPTH-1.
  - Presses while rom_full are ignored. There is no wrap.
- **CHECK**
  - On entry from any other state, check_ptr <= 0.
  - Each press increments check_ptr modulo ROM_DEPTH (wraps 31 -> 0 at default depth).
  - check_out is combinational from rom[check_ptr].
- **Mode changes**
  - load_ptr and rom_full are retained across mode changes, so a load can be resumed.
  - Presses in IDLE or RUN have no effect.
- **RUN address decode**
  - addr < ROM_DEPTH: ROM region, index addr[ROM_AW-1:0].
  - ROM_DEPTH <= addr < ROM_DEPTH+RAM_DEPTH: RAM region, index addr-ROM_DEPTH.
  - Anything else: out of range.
- **RUN write** (write==1 sampled):
  - RAM region: ram[idx] <= data_in.
  - ROM region or out of range: write discarded, err <= 1.
- **RUN read** (read==1 sampled):
  - ROM or RAM region: data register <= the addressed entry.
  - Out of range: data register <= 0, err <= 1.
  - In both cases rd_valid <= 1. If read==0, rd_valid <= 0 and the data register holds.
- **Simultaneous read and write, same address**: the write is performed and the read returns the pre-write contents (read-before-write).
- **Outside RUN**: read and write are ignored and rd_valid is forced to 0.
- **err** is cleared only by reset.
- **Reset** clears:
  - load_ptr, check_ptr, rom_full, err, rd_valid and the data register, all to 0.
  - rom and ram contents are NOT cleared.
  - data_out and check_out follow cpustate: 0 or high-Z.

## Timing
- **Press latency**: key low sampled at edge E -> k1 at E, k2 at E+1 -> press pulse during cycle E+1..E+2.
  - The memory write / pointer increment happens at edge E+2.
  - load_ptr and check_out reflect it after E+2.
- **Read latency**: 1 cycle.
  - read sampled at edge N -> data_out valid and rd_valid=1 from N until N+1.
  - Back-to-back reads give one result per cycle.
- **Write latency**: a write sampled at edge N is visible to a read sampled at edge N+1.
- **Reset**: a reset sampled at an edge overrides every other action on that edge, including a pending press pulse and an in-progress read or write.
- **check_ptr entry clear**: takes effect on the first edge with cpustate==10. A press coinciding with that edge is applied after the clear, giving check_ptr=1.

## Test plan
- **Full load**: reset; IN; 32 presses with sw=0x10+i. Expect load_ptr to step 0..31; rom_full=1 after the 32nd press; a 33rd press leaves rom[31]=0x2F.
- **CHECK walk**: after the load, CHECK; 33 presses. Expect check_out 0x10, 0x11, …, 0x2F, then 0x10 (wrap); check_out high-Z when cpustate=01.
- **RUN RAM**: write 0xA5 to addr 0x0020, then read 0x0020. Expect data_out=0xA5 and rd_valid=1 one cycle after the read; a ROM read of 0x0003 returns 0x13.
- **Illegal access**: RUN write to 0x0005 leaves rom[5]=0x15 and sets err=1. Read of 0x00A0 (=ROM_DEPTH+RAM_DEPTH) returns 0 and keeps err=1 until reset.
- **Simultaneous read/write**: ram[0x0021]=0x11. Read+write 0x22 to addr 0x0021 in the same cycle returns 0x11; the next read returns 0x22.
- **Reset mid-operation**: assert reset during a press pulse. Expect load_ptr=0, rom_full=0, err=0, rd_valid=0 next cycle; previously loaded rom contents still readable in CHECK.

Source files
------------

// File: rtl/prog_data_mem.sv
// rtl/prog_data_mem.sv - parametrised program store / data RAM for the tiny CPU
// Key-driven program entry (IN), program review (CHECK) and CPU bus access (RUN).
module prog_data_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int ROM_DEPTH = 32,
    parameter int RAM_DEPTH = 128,
    localparam int ROM_AW   = $clog2(ROM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cpustate,
    input  logic              key,
    input  logic [DATA_W-1:0] sw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [DATA_W-1:0] check_out,
    output logic [ROM_AW-1:0] load_ptr,
    output logic              rom_full,
    output logic              err
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'b00,
        CS_IN    = 2'b01,
        CS_CHECK = 2'b10,
        CS_RUN   = 2'b11
    } cpu_state_e;

    cpu_state_e cs;
    cpu_state_e prev_cs_q;

    assign cs = cpu_state_e'(cpustate);

    logic [DATA_W-1:0] rom_q [ROM_DEPTH];
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];

    // Key synchronizer plus history flop; idle-high so reset never fakes a press.
    logic k1_q, k2_q, kp_q;
    logic press;

    always_ff @(posedge clk) begin
        if (reset) begin
            k1_q <= 1'b1;
            k2_q <= 1'b1;
            kp_q <= 1'b1;
        end else begin
            k1_q <= key;
            k2_q <= k1_q;
            kp_q <= k2_q;
        end
    end

    assign press = ~k2_q & kp_q;

    logic [ROM_AW-1:0] load_ptr_q, load_ptr_d;
    logic              rom_full_q, rom_full_d;
    logic              rom_we;

    always_comb begin
        load_ptr_d = load_ptr_q;
        rom_full_d = rom_full_q;
        rom_we     = 1'b0;
        if (cs == CS_IN && press && !rom_full_q) begin
            rom_we = 1'b1;
            if (load_ptr_q == ROM_AW'(ROM_DEPTH - 1)) begin
                rom_full_d = 1'b1;
            end else begin
                load_ptr_d = load_ptr_q + ROM_AW'(1);
            end
        end
    end

    logic [ROM_AW-1:0] check_ptr_q, check_ptr_d;

    // Entry clear first, then a coinciding press still counts.
    always_comb begin
        check_ptr_d = check_ptr_q;
        if (cs == CS_CHECK) begin
            if (prev_cs_q != CS_CHECK) begin
                check_ptr_d = '0;
            end
            if (press) begin
                check_ptr_d = check_ptr_d + ROM_AW'(1);
            end
        end
    end

    logic              in_rom, in_ram;
    logic [ROM_AW-1:0] rom_idx;
    logic [ADDR_W-1:0] ram_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_ram_off_hi;

    assign in_rom            = addr < ADDR_W'(ROM_DEPTH);
    assign in_ram            = !in_rom && (addr < ADDR_W'(ROM_DEPTH + RAM_DEPTH));
    assign rom_idx           = addr[ROM_AW-1:0];
    assign ram_off           = addr - ADDR_W'(ROM_DEPTH);
    assign ram_idx           = ram_off[RAM_AW-1:0];
    assign unused_ram_off_hi = ^ram_off[ADDR_W-1:RAM_AW];

    logic              run_rd, run_wr, ram_we;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    assign run_rd = (cs == CS_RUN) && read;
    assign run_wr = (cs == CS_RUN) && write;

    // The read path samples the array before this edge's write lands: read-before-write.
    always_comb begin
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        ram_we     = 1'b0;
        if (run_rd) begin
            rd_valid_d = 1'b1;
            if (in_rom) begin
                rdata_d = rom_q[rom_idx];
            end else if (in_ram) begin
                rdata_d = ram_q[ram_idx];
            end else begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
        if (run_wr) begin
            if (in_ram) begin
                ram_we = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_ptr_q  <= '0;
            rom_full_q  <= 1'b0;
            check_ptr_q <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            prev_cs_q   <= CS_IDLE;
        end else begin
            load_ptr_q  <= load_ptr_d;
            rom_full_q  <= rom_full_d;
            check_ptr_q <= check_ptr_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
            prev_cs_q   <= cs;
        end
    end

    // Array contents survive reset; reset only blocks writes on its own edge.
    always_ff @(posedge clk) begin
        if (!reset && rom_we) begin
            rom_q[load_ptr_q] <= sw;
        end
        if (!reset && ram_we) begin
            ram_q[ram_idx] <= data_in;
        end
    end

    assign data_out  = (cs == CS_RUN)   ? rdata_q            : {DATA_W{1'bz}};
    assign check_out = (cs == CS_CHECK) ? rom_q[check_ptr_q] : {DATA_W{1'bz}};
    assign load_ptr  = load_ptr_q;
    assign rom_full  = rom_full_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_data_mem.sv
// tb/tb_prog_data_mem.sv - self-checking bench for prog_data_mem
// Reference model tracks program store, data RAM, pointers and error flag by rule.
module tb_prog_data_mem;

    logic        clk = 1'b0;
    logic        reset, key, read, write;
    logic [1:0]  cpustate;
    logic [7:0]  sw, data_in;
    logic [15:0] addr;
    wire  [7:0]  data_out, check_out;
    wire  [4:0]  load_ptr;
    wire         rom_full, err, rd_valid;

    prog_data_mem dut (
        .clk(clk), .reset(reset), .cpustate(cpustate), .key(key), .sw(sw),
        .addr(addr), .data_in(data_in), .read(read), .write(write),
        .data_out(data_out), .rd_valid(rd_valid), .check_out(check_out),
        .load_ptr(load_ptr), .rom_full(rom_full), .err(err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;

    logic [7:0] rom_m [32];
    logic [7:0] ram_m [128];
    int         lp_m, cp_m;
    bit         full_m, err_m, exp_rdv;
    logic [7:0] exp_data;

    task automatic model_reset();
        lp_m = 0; cp_m = 0; full_m = 0; err_m = 0; exp_rdv = 0; exp_data = 8'h00;
    endtask

    task automatic model_in_press(input logic [7:0] v);
        if (!full_m) begin
            rom_m[lp_m] = v;
            if (lp_m == 31) full_m = 1; else lp_m = lp_m + 1;
        end
    endtask

    task automatic model_op(input int a, input bit rd, input bit wr, input logic [7:0] wd);
        exp_rdv = rd;
        if (rd) begin
            if (a < 32) exp_data = rom_m[a];
            else if (a < 160) exp_data = ram_m[a - 32];
            else begin exp_data = 8'h00; err_m = 1; end
        end
        if (wr) begin
            if (a >= 32 && a < 160) ram_m[a - 32] = wd;
            else err_m = 1;
        end
    endtask

    task automatic press(input bit rst_hit, input logic [1:0] mid_cs, output logic [4:0] mid_ptr);
        key = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        mid_ptr  = load_ptr;
        cpustate = mid_cs;
        if (rst_hit) begin reset = 1'b1; key = 1'b1; end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        key = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cpu_op(input int a, input bit rd, input bit wr, input logic [7:0] wd);
        addr = 16'(a); read = rd; write = wr; data_in = wd;
        @(posedge clk); @(negedge clk);
        read = 1'b0; write = 1'b0;
        if (cpustate == 2'b11) model_op(a, rd, wr, wd); else exp_rdv = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; key = 1'b1; cpustate = 2'b01; read = 0; write = 0;
        sw = 8'h00; addr = 16'h0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        nchk++; if (load_ptr !== 5'd0) begin nbad++; $display("FAIL reset_load_ptr: got %0d want 0", load_ptr); end
        nchk++; if (rom_full !== 1'b0) begin nbad++; $display("FAIL reset_rom_full: got %b want 0", rom_full); end
        nchk++; if (err !== 1'b0) begin nbad++; $display("FAIL reset_err: got %b want 0", err); end
        nchk++; if (rd_valid !== 1'b0) begin nbad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_full_load();
        logic [4:0] mid;
        cpustate = 2'b01;
        for (int i = 0; i < 33; i++) begin
            sw = (i < 32) ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
            nchk++; if (load_ptr !== 5'(lp_m)) begin nbad++; $display("FAIL load_ptr_before[%0d]: got %0d want %0d", i, load_ptr, lp_m); end
            press(0, 2'b01, mid);
            nchk++; if (mid !== 5'(lp_m)) begin nbad++; $display("FAIL press_latency[%0d]: got %0d want %0d", i, mid, lp_m); end
            model_in_press(sw);
            nchk++; if (load_ptr !== 5'(lp_m)) begin nbad++; $display("FAIL load_ptr_after[%0d]: got %0d want %0d", i, load_ptr, lp_m); end
            nchk++; if (rom_full !== full_m) begin nbad++; $display("FAIL rom_full[%0d]: got %b want %b", i, rom_full, full_m); end
        end
    endtask

    task automatic test_check_walk();
        logic [4:0] mid;
        cpustate = 2'b01;
        press(0, 2'b10, mid);
        cp_m = 1;
        nchk++; if (check_out !== rom_m[cp_m]) begin nbad++; $display("FAIL check_entry_press: got %0h want %0h", check_out, rom_m[cp_m]); end
        cpustate = 2'b00; @(negedge clk);
        cpustate = 2'b10; @(negedge clk);
        cp_m = 0;
        nchk++; if (check_out !== rom_m[0]) begin nbad++; $display("FAIL check_entry_clear: got %0h want %0h", check_out, rom_m[0]); end
        for (int i = 0; i < 33; i++) begin
            press(0, 2'b10, mid);
            cp_m = (cp_m + 1) % 32;
            nchk++; if (check_out !== rom_m[cp_m]) begin nbad++; $display("FAIL check_walk[%0d]: got %0h want %0h", i, check_out, rom_m[cp_m]); end
        end
        nchk++; if (rom_m[31] !== 8'h2F) begin nbad++; $display("FAIL rom31_model: got %0h want 2f", rom_m[31]); end
    endtask

    task automatic test_run_ram();
        cpustate = 2'b11; @(negedge clk);
        nchk++; if (data_out !== exp_data) begin nbad++; $display("FAIL run_entry_data: got %0h want %0h", data_out, exp_data); end
        for (int j = 0; j < 128; j++) cpu_op(32 + j, 0, 1, 8'($urandom_range(0, 255)));
        cpu_op(16'h0020, 0, 1, 8'hA5);
        cpu_op(16'h0020, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'hA5) begin nbad++; $display("FAIL ram_read: got %0h want a5", data_out); end
        nchk++; if (rd_valid !== 1'b1) begin nbad++; $display("FAIL ram_rd_valid: got %b want 1", rd_valid); end
        cpu_op(16'h0003, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'h13) begin nbad++; $display("FAIL rom_read: got %0h want 13", data_out); end
        cpu_op(0, 0, 0, 8'h00);
        nchk++; if (rd_valid !== 1'b0) begin nbad++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
        nchk++; if (data_out !== exp_data) begin nbad++; $display("FAIL idle_data_hold: got %0h want %0h", data_out, exp_data); end
        nchk++; if (err !== 1'b0) begin nbad++; $display("FAIL legal_err: got %b want 0", err); end
    endtask

    task automatic test_illegal();
        cpu_op(16'h0005, 0, 1, 8'h77);
        nchk++; if (err !== 1'b1) begin nbad++; $display("FAIL rom_write_err: got %b want 1", err); end
        cpu_op(16'h0005, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'h15) begin nbad++; $display("FAIL rom_unchanged: got %0h want 15", data_out); end
        cpu_op(16'h009F, 0, 1, 8'h3C);
        cpu_op(16'h009F, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'h3C) begin nbad++; $display("FAIL ram_top: got %0h want 3c", data_out); end
        cpu_op(16'h00A0, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'h00) begin nbad++; $display("FAIL oor_read: got %0h want 0", data_out); end
        nchk++; if (rd_valid !== 1'b1) begin nbad++; $display("FAIL oor_rd_valid: got %b want 1", rd_valid); end
        repeat (3) cpu_op(0, 0, 0, 8'h00);
        nchk++; if (err !== 1'b1) begin nbad++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_simul();
        cpu_op(16'h0021, 0, 1, 8'h11);
        cpu_op(16'h0021, 1, 1, 8'h22);
        nchk++; if (data_out !== 8'h11) begin nbad++; $display("FAIL rbw_old: got %0h want 11", data_out); end
        cpu_op(16'h0021, 1, 0, 8'h00);
        nchk++; if (data_out !== 8'h22) begin nbad++; $display("FAIL rbw_new: got %0h want 22", data_out); end
    endtask

    task automatic test_outside_run();
        cpustate = 2'b00;
        cpu_op(16'h0030, 1, 1, 8'h5A);
        nchk++; if (rd_valid !== 1'b0) begin nbad++; $display("FAIL idle_read_ignored: got %b want 0", rd_valid); end
        cpustate = 2'b11;
        cpu_op(16'h0030, 1, 0, 8'h00);
        nchk++; if (data_out !== exp_data) begin nbad++; $display("FAIL idle_write_ignored: got %0h want %0h", data_out, exp_data); end
    endtask

    task automatic test_random();
        int a;
        bit rd, wr;
        for (int i = 0; i < 80; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(160, 16'hFFFF)) : int'($urandom_range(0, 159));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            cpu_op(a, rd, wr, 8'($urandom_range(0, 255)));
            nchk++; if (data_out !== exp_data || rd_valid !== exp_rdv || err !== err_m) begin
                nbad++;
                $display("FAIL rand[%0d] a=%0h: got d=%0h v=%b e=%b want d=%0h v=%b e=%b", i, a, data_out, rd_valid, err, exp_data, exp_rdv, err_m);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] mid;
        addr = 16'h0021; read = 1'b1; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; read = 1'b0;
        model_reset();
        nchk++; if (rd_valid !== 1'b0) begin nbad++; $display("FAIL rst_read_rd_valid: got %b want 0", rd_valid); end
        nchk++; if (err !== 1'b0) begin nbad++; $display("FAIL rst_err: got %b want 0", err); end
        nchk++; if (data_out !== 8'h00) begin nbad++; $display("FAIL rst_data: got %0h want 0", data_out); end
        cpustate = 2'b01; sw = 8'h99; @(negedge clk);
        press(1, 2'b01, mid);
        nchk++; if (load_ptr !== 5'd0) begin nbad++; $display("FAIL rst_press_load_ptr: got %0d want 0", load_ptr); end
        nchk++; if (rom_full !== 1'b0) begin nbad++; $display("FAIL rst_press_rom_full: got %b want 0", rom_full); end
        cpustate = 2'b10; @(negedge clk);
        nchk++; if (check_out !== 8'h10) begin nbad++; $display("FAIL rst_rom_kept: got %0h want 10", check_out); end
        for (int i = 0; i < 3; i++) begin
            press(0, 2'b10, mid);
            cp_m = cp_m + 1;
            nchk++; if (check_out !== rom_m[cp_m]) begin nbad++; $display("FAIL rst_walk[%0d]: got %0h want %0h", i, check_out, rom_m[cp_m]); end
        end
        cpustate = 2'b01; sw = 8'h5D; @(negedge clk);
        press(0, 2'b01, mid);
        model_in_press(8'h5D);
        nchk++; if (load_ptr !== 5'(lp_m)) begin nbad++; $display("FAIL resume_load: got %0d want %0d", load_ptr, lp_m); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_load();
        test_check_walk();
        test_run_ram();
        test_illegal();
        test_simul();
        test_outside_run();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
